// File: rtl/sample_write_arbiter.sv
// Sole writer of the 48-bit sample FIFO: merges timer samples, laser-change, lost-sample and
// (with HEARTBEAT_EN defined) heartbeat records into one prioritised, registered write stream.
module sample_write_arbiter #(
    parameter int unsigned LOST_WIDTH = 16,
    parameter logic [23:0] HB_PERIOD  = 24'd8000000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  timer_rdy,
    input  logic [43:0]           timer_data,
    input  logic [3:0]            laser_en,
    input  logic                  fifo_afull,
    output logic                  fifo_wrreq,
    output logic [47:0]           fifo_data,
    output logic                  sample_written,
    output logic [LOST_WIDTH-1:0] lost_count
);

    localparam logic [3:0] TypeLaser = 4'h1;
    localparam logic [3:0] TypeLost  = 4'h2;
    localparam logic [3:0] TypeHb    = 4'h3;

    logic                  wrreq_q, wrreq_d;
    logic [47:0]           data_q, data_d;
    logic                  sw_q, sw_d;
    logic [LOST_WIDTH-1:0] lost_q, lost_d;
    logic [3:0]            last_laser_q, last_laser_d;
    logic                  laser_pend_q, laser_pend_d;
    logic                  hb_pend;
    logic [35:0]           hb_seq;

    logic sel_timer, sel_lost, sel_laser, sel_hb, drop, ctrl_ok;
    logic [35:0] lost_ext;

    assign lost_ext = 36'(lost_q);

    // Control records only go out when the timer is idle and the FIFO has room.
    always_comb begin
        drop      = timer_rdy & fifo_afull;
        sel_timer = timer_rdy & ~fifo_afull;
        ctrl_ok   = ~timer_rdy & ~fifo_afull;
        sel_lost  = ctrl_ok & (lost_q != '0);
        sel_laser = ctrl_ok & ~sel_lost & enable & laser_pend_q;
        sel_hb    = ctrl_ok & ~sel_lost & ~laser_pend_q & enable & hb_pend;
    end

    always_comb begin
        wrreq_d = 1'b0;
        sw_d    = 1'b0;
        data_d  = data_q;
        if (sel_timer) begin
            wrreq_d = 1'b1;
            sw_d    = 1'b1;
            data_d  = {laser_en, timer_data};
        end else if (sel_lost) begin
            wrreq_d = 1'b1;
            data_d  = {laser_en, 4'h0, TypeLost, lost_ext};
        end else if (sel_laser) begin
            wrreq_d = 1'b1;
            data_d  = {laser_en, 4'h0, TypeLaser, 28'b0, last_laser_q, laser_en};
        end else if (sel_hb) begin
            wrreq_d = 1'b1;
            data_d  = {laser_en, 4'h0, TypeHb, hb_seq};
        end
    end

    always_comb begin
        lost_d = lost_q;
        if (drop) begin
            if (lost_q != '1) begin
                lost_d = lost_q + LOST_WIDTH'(1);
            end
        end else if (sel_lost) begin
            lost_d = '0;
        end
    end

    // Laser changes coalesce until issued; while disabled the reference just follows laser_en.
    always_comb begin
        last_laser_d = last_laser_q;
        laser_pend_d = laser_pend_q;
        if (!enable) begin
            last_laser_d = laser_en;
            laser_pend_d = 1'b0;
        end else if (sel_laser) begin
            last_laser_d = laser_en;
            laser_pend_d = 1'b0;
        end else if (laser_en != last_laser_q) begin
            laser_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrreq_q      <= 1'b0;
            data_q       <= '0;
            sw_q         <= 1'b0;
            lost_q       <= '0;
            last_laser_q <= '0;
            laser_pend_q <= 1'b0;
        end else begin
            wrreq_q      <= wrreq_d;
            data_q       <= data_d;
            sw_q         <= sw_d;
            lost_q       <= lost_d;
            last_laser_q <= last_laser_d;
            laser_pend_q <= laser_pend_d;
        end
    end

`ifdef HEARTBEAT_EN
    logic [23:0] hb_cnt_q;
    logic        hb_pend_q;
    logic [35:0] hb_seq_q;

    assign hb_pend = hb_pend_q;
    assign hb_seq  = hb_seq_q;

    // Terminal count while already pending is absorbed; issuing clears the flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hb_cnt_q  <= '0;
            hb_pend_q <= 1'b0;
            hb_seq_q  <= '0;
        end else if (!enable) begin
            hb_cnt_q  <= '0;
            hb_pend_q <= 1'b0;
        end else begin
            if (hb_cnt_q == HB_PERIOD - 24'd1) begin
                hb_cnt_q  <= '0;
                hb_pend_q <= 1'b1;
            end else begin
                hb_cnt_q <= hb_cnt_q + 24'd1;
            end
            if (sel_hb) begin
                hb_pend_q <= 1'b0;
                hb_seq_q  <= hb_seq_q + 36'd1;
            end
        end
    end
`else
    assign hb_pend = 1'b0;
    assign hb_seq  = '0;
`endif

    assign fifo_wrreq     = wrreq_q;
    assign fifo_data      = data_q;
    assign sample_written = sw_q;
    assign lost_count     = lost_q;

endmodule

// File: doc/sample_write_arbiter.md
Name: sample_write_arbiter

Overview:
- Sole writer of the 48-bit sample FIFO write port in the clk domain.
- Merges three record sources into one ordered stream toward the host:
  - apdtimer detector samples;
  - laser-enable change records;
  - lost-sample reports.
- Counts timer samples dropped on FIFO back-pressure and reports them in-band, so the host sees every gap explicitly.
- Replaces the direct sample_rdy & ~full write gating.

Parameters:
- LOST_WIDTH, 16: width of the saturating lost-sample counter (must be ≤ 36).
- HB_PERIOD, 24'd8000000: heartbeat interval in clk cycles (used only with HEARTBEAT_EN).

Ports:
- clk  input  1  sample-domain clock.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  apdtimer running flag; gates control records.
- timer_rdy  input  1  one-cycle strobe, timer_data valid.
- timer_data  input  44  apdtimer record; bits 43:40 are the detector-hit mask, never 0 for a real sample.
- laser_en  input  4  current pulse sequencer outputs.
- fifo_afull  input  1  FIFO almost-full; asserted with ≥1 word of headroom.
- fifo_wrreq  output  1  registered FIFO write strobe.
- fifo_data  output  48  registered FIFO write data.
- sample_written  output  1  high with fifo_wrreq when the record is a timer sample; drives the length summator.
- lost_count  output  LOST_WIDTH  current un-reported loss count.

Behaviour:
- Reset: all outputs 0, pending flags 0, last_laser = 0, heartbeat counter and sequence number 0. Reset mid-operation discards pending records and any lost count.
- Record formats:
  - Timer record = {laser_en, timer_data}.
  - Control record = {laser_en, 4'h0, type[3:0], payload[35:0]}. The 4'h0 in bits 43:40 marks a control record.
  - type 1, laser change: payload = {28'b0, last_laser, laser_en}.
  - type 2, lost report: payload = lost_count zero-extended.
  - type 3, heartbeat: payload = 36-bit sequence number.
- Each cycle the arbiter selects at most one record. fifo_wrreq/fifo_data update on the next edge (latency 1). With no selection, fifo_wrreq = 0 and fifo_data holds its last value.
- Fixed priority, highest first:
  1. timer sample;
  2. lost report (lost_count != 0);
  3. laser change pending;
  4. heartbeat pending.
- Lower-priority sources wait; they are never dropped.
- Timer sample while fifo_afull = 1:
  - no write;
  - lost_count increments, saturating at all-ones.
- Lost report:
  - issued only when fifo_afull = 0 and timer_rdy = 0;
  - lost_count clears on issue.
  - A timer loss in the same cycle as the report is impossible, since the report requires timer_rdy = 0.
  - The report carries the saturated value if saturated.
- Laser change:
  - laser_en != last_laser sets laser_pend.
  - On issue, the payload captures last_laser and the current laser_en; then last_laser <= laser_en and laser_pend clears.
  - Multiple changes before issue coalesce into one record.
  - If laser_en has returned to last_laser at issue time, the record is still emitted (old == new).
- enable = 0:
  - laser_pend and heartbeat pending clear; last_laser tracks laser_en.
  - Timer samples and lost reports still arbitrate.
  - lost_count is retained.
- No control record is written while fifo_afull = 1.

Optional Feature:
- HEARTBEAT_EN, defined:
  - A counter runs while enable = 1 and sets hb_pend every HB_PERIOD cycles.
  - A type-3 record is emitted at lowest priority; the sequence number increments after each emission and wraps modulo 2^36.
  - A terminal count while hb_pend is already set is absorbed (no double record).
  - The counter resets to 0 when enable falls.
- HEARTBEAT_EN, undefined:
  - No counter logic.
  - Type 3 is never emitted.

Test Plan:
- Reset → a single timer_rdy with timer_data = 44'h1_0000000ABC and laser_en = 4'h5 → next cycle fifo_wrreq = 1, sample_written = 1, fifo_data = 48'h51_0000000ABC.
- Hold fifo_afull = 1 across 3 timer strobes, then release with idle input → lost_count = 3, then one write of {laser_en, 4'h0, 4'h2, 36'd3} and lost_count = 0.
- enable = 1; laser_en 0→1→3 in consecutive cycles while timer_rdy is high every cycle; then timer goes idle → timer records first, then exactly one type-1 record with payload 36'h03 (old 0, new 3).
- Reach saturation with LOST_WIDTH = 4: 20 drops → lost_count = 4'hF; the report payload is 36'hF.
- HEARTBEAT_EN with HB_PERIOD = 10, enable = 1, idle inputs → type-3 records at 10-cycle intervals with payloads 0, 1, 2. Drop enable mid-period → no further heartbeats.
- Assert reset_n = 0 asynchronously while laser_pend is set and lost_count = 2 → outputs are immediately 0, and no record is emitted after release.
